alu_arbiter: RTL and testbench

//   Shares the single combinational ALU between two requesters (req0, req1), e.g. execute stage
//   and branch/address unit. Round-robin grant of one operation per cycle, ALU operands muxed from
//   the granted requester, result registered into a per-requester response slot with valid/ready.

---
 rtl/alu_arbiter_if.sv | 56 +++++
 rtl/alu_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles the requester handshakes, the response slots and the shared ALU
//   connection of alu_arbiter into one interface.
//   master : the system side. It drives the requests, consumes the responses
//            and returns alu_out from the external combinational ALU.
//   slave  : the arbiter side (alu_arbiter).
//   Signals
//     reqN_valid/ready/a/b/sel : request handshake and operands for N = 0, 1
//     rspN_valid/ready/data    : registered result slot for N = 0, 1
//     alu_a/alu_b/alu_sel      : operands routed to the shared ALU
//     alu_out                  : result from the shared ALU, same cycle
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [SEL_W-1:0]  req0_sel;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [SEL_W-1:0]  req1_sel;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [DATA_W-1:0] alu_out;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output rsp0_ready, rsp1_ready, alu_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  alu_a, alu_b, alu_sel
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  rsp0_ready, rsp1_ready, alu_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational ALU between two requesters. It grants at most
//   one operation per cycle in round-robin order, routes the granted
//   operands to the ALU, and registers the ALU result into that requester's
//   response slot, which has its own valid/ready handshake.
//   Ports
//     clk          : clock, rising edge
//     rst_n        : synchronous reset, active low
//     bus (slave)  : requests, response slots and ALU connection
//     gnt_cnt0/1   : saturating grant counters      (ALU_ARB_STATS_EN only)
//     conflict_cnt : saturating contention counter  (ALU_ARB_STATS_EN only)
//   Configuration macro
//     ALU_ARB_STATS_EN : when defined, adds the statistics counters and their
//                        output ports.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  // Requester-indexed views of the interface, so both slots share one code path.
  logic [1:0]        w_req_valid;
  logic [1:0]        w_rsp_ready;
  logic [DATA_W-1:0] w_req_a   [2];
  logic [DATA_W-1:0] w_req_b   [2];
  logic [SEL_W-1:0]  w_req_sel [2];
  logic [1:0]        w_elig;
  logic [1:0]        w_gnt;

  logic [1:0]        r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data [2];
  logic              r_last_gnt;   // index of the requester granted most recently

  assign w_req_valid  = {bus.req1_valid, bus.req0_valid};
  assign w_rsp_ready  = {bus.rsp1_ready, bus.rsp0_ready};
  assign w_req_a[0]   = bus.req0_a;
  assign w_req_a[1]   = bus.req1_a;
  assign w_req_b[0]   = bus.req0_b;
  assign w_req_b[1]   = bus.req1_b;
  assign w_req_sel[0] = bus.req0_sel;
  assign w_req_sel[1] = bus.req1_sel;

  // A requester is eligible when its slot is empty or is being drained this
  // same cycle; this keeps per-requester throughput at one op per cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign w_elig[gi] = w_req_valid[gi] && (!r_rsp_valid[gi] || w_rsp_ready[gi]);
  end

  // Round-robin: when both are eligible, the one not granted last time wins.
  // No grant at all while reset is asserted.
  always_comb begin
    w_gnt = 2'b00;
    if (rst_n) begin
      if (w_elig == 2'b11) begin
        w_gnt = r_last_gnt ? 2'b01 : 2'b10;
      end else begin
        w_gnt = w_elig;
      end
    end
  end

  assign bus.req0_ready = w_gnt[0];
  assign bus.req1_ready = w_gnt[1];

  // Operand mux to the ALU; idle cycles present zeros.
  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_sel = '0;
    if (w_gnt[0]) begin
      bus.alu_a   = w_req_a[0];
      bus.alu_b   = w_req_b[0];
      bus.alu_sel = w_req_sel[0];
    end else if (w_gnt[1]) begin
      bus.alu_a   = w_req_a[1];
      bus.alu_b   = w_req_b[1];
      bus.alu_sel = w_req_sel[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
    end else if (w_gnt[1]) begin
      r_last_gnt <= 1'b1;
    end else if (w_gnt[0]) begin
      r_last_gnt <= 1'b0;
    end
  end

  // Response slots. A grant takes priority over a drain, so a slot that is
  // drained and refilled in the same cycle stays valid with the new result.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        r_rsp_valid[i] <= 1'b0;
        r_rsp_data[i]  <= '0;
      end else if (w_gnt[i]) begin
        r_rsp_valid[i] <= 1'b1;
        r_rsp_data[i]  <= bus.alu_out;
      end else if (w_rsp_ready[i]) begin
        r_rsp_valid[i] <= 1'b0;
      end
    end
  end

  assign bus.rsp0_valid = r_rsp_valid[0];
  assign bus.rsp1_valid = r_rsp_valid[1];
  assign bus.rsp0_data  = r_rsp_data[0];
  assign bus.rsp1_data  = r_rsp_data[1];

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Index 0/1 are the per-requester grant counters, index 2 counts contention.
  logic [2:0]       w_cnt_inc;
  logic [CNT_W-1:0] r_cnt [3];

  assign w_cnt_inc = {(w_elig == 2'b11), w_gnt[1], w_gnt[0]};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        r_cnt[i] <= '0;
      end else if (w_cnt_inc[i] && (r_cnt[i] != CNT_MAX)) begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign gnt_cnt0     = r_cnt[0];
  assign gnt_cnt1     = r_cnt[1];
  assign conflict_cnt = r_cnt[2];
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. The stimulus pushes hand-computed results
//   into per-requester queues when an operation is accepted. A monitor pops
//   and compares each result whenever a response slot is consumed.
//   Inputs change 1 time unit after the rising edge. Outputs are sampled on
//   the falling edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

`ifdef ALU_ARB_STATS_EN
  localparam int CW = 4;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32), .SEL_W(4)) bus ();

  alu_arbiter #(.DATA_W(32), .SEL_W(4), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt_cnt0     (gnt_cnt0),
    .gnt_cnt1     (gnt_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // External shared ALU (combinational).
  always_comb begin
    bus.alu_out = '0;
    case (bus.alu_sel)
      OP_ADD:  bus.alu_out = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_out = bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_out = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_out = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      OP_SLL:  bus.alu_out = bus.alu_a << bus.alu_b[4:0];
      OP_SRL:  bus.alu_out = bus.alu_a >> bus.alu_b[4:0];
      OP_SRA:  bus.alu_out = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      default: bus.alu_out = '0;
    endcase
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare each consumed response with the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        if (q0.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp0_unexpected: got %h expected no response", bus.rsp0_data);
        end else begin
          $display("rsp0 data=%h", bus.rsp0_data);
          chk("rsp0_data", bus.rsp0_data, q0.pop_front());
        end
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp1_unexpected: got %h expected no response", bus.rsp1_data);
        end else begin
          $display("rsp1 data=%h", bus.rsp1_data);
          chk("rsp1_data", bus.rsp1_data, q1.pop_front());
        end
      end
    end
  end

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = s;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset held two cycles with both requests pending.
    rst_n = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    set0(1'b1, 32'd5, 32'd3, OP_SUB);
    set1(1'b1, 32'd9, 32'd9, OP_ADD);
    @(negedge clk);
    chk("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
    chk("rst_alu_sel", {28'b0, bus.alu_sel}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    @(negedge clk);
    chk("rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
    chk("rst_rsp0_data", bus.rsp0_data, 32'd0);
    chk("rst_rsp1_data", bus.rsp1_data, 32'd0);

    // 2. Lone req0: 5 - 3 = 2, result one cycle later.
    drive();
    rst_n = 1'b1;
    set1(1'b0, 32'd0, 32'd0, OP_ADD);
    @(negedge clk);
    chk("t2_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
    chk("t2_alu_sel", {28'b0, bus.alu_sel}, {28'b0, OP_SUB});
    chk("t2_alu_a", bus.alu_a, 32'd5);
    chk("t2_rsp0_valid_T", {31'b0, bus.rsp0_valid}, 32'd0);
    q0.push_back(32'd2);
    drive();
    set0(1'b0, 32'd0, 32'd0, OP_ADD);
    @(negedge clk);
    chk("t2_rsp0_valid_T1", {31'b0, bus.rsp0_valid}, 32'd1);
    chk("t2_idle_alu_b", bus.alu_b, 32'd0);

    // 3. Both requesting every cycle; last grant was req0, so req1 goes first.
    drive();
    set0(1'b1, 32'd10, 32'd20, OP_ADD);
    set1(1'b1, 32'hFFFF_FFF8, 32'd1, OP_SRA);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_rr_gnt1", {31'b0, bus.req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_rr_gnt0", {31'b0, bus.req0_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) q1.push_back(32'hFFFF_FFFC);
      else            q0.push_back(32'd30);
    end
    drive();
    set0(1'b0, 32'd0, 32'd0, OP_ADD);
    set1(1'b0, 32'd0, 32'd0, OP_ADD);

    // 4. Slot 0 held full: req1 wins every cycle, then req0 on release.
    drive();
    bus.rsp0_ready = 1'b0;
    set0(1'b1, 32'd7, 32'd2, OP_AND);
    @(negedge clk);
    chk("t4_fill_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
    q0.push_back(32'd2);
    drive();
    set0(1'b1, 32'h0000_00F0, 32'h0000_000F, OP_XOR);
    set1(1'b1, 32'd1, 32'd2, OP_OR);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_blk_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
      chk("t4_blk_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
      chk("t4_hold_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
      chk("t4_hold_rsp0_data", bus.rsp0_data, 32'd2);
      q1.push_back(32'd3);
    end
    drive();
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    chk("t4_rel_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
    chk("t4_rel_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
    q0.push_back(32'h0000_00FF);
    drive();
    set0(1'b0, 32'd0, 32'd0, OP_ADD);
    @(negedge clk);
    chk("t4_after_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
    chk("t4_new_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd1);
    q1.push_back(32'd3);
    drive();
    set1(1'b0, 32'd0, 32'd0, OP_ADD);

    // 5. Reset with slot 1 full and req0 pending; last grant before it was req0.
    drive();
    bus.rsp1_ready = 1'b0;
    set1(1'b1, 32'd1, 32'd1, OP_ADD);
    @(negedge clk);
    chk("t5_req1_ready", {31'b0, bus.req1_ready}, 32'd1);
    q1.push_back(32'd2);
    drive();
    set1(1'b0, 32'd0, 32'd0, OP_ADD);
    set0(1'b1, 32'd2, 32'd2, OP_ADD);
    @(negedge clk);
    chk("t5_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
    chk("t5_rsp1_full", {31'b0, bus.rsp1_valid}, 32'd1);
    q0.push_back(32'd4);
    drive();
    rst_n = 1'b0;
    set0(1'b1, 32'd4, 32'd4, OP_ADD);
    set1(1'b1, 32'd3, 32'd3, OP_ADD);
    @(negedge clk);
    chk("t5_rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
    chk("t5_rst_alu_a", bus.alu_a, 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk("t5_rst_rsp1_valid", {31'b0, bus.rsp1_valid}, 32'd0);
    chk("t5_rst_rsp1_data", bus.rsp1_data, 32'd0);
    chk("t5_rst_rsp0_valid", {31'b0, bus.rsp0_valid}, 32'd0);
    drive();
    rst_n = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    chk("t5_first_gnt0", {31'b0, bus.req0_ready}, 32'd1);
    chk("t5_first_gnt1", {31'b0, bus.req1_ready}, 32'd0);
    q0.push_back(32'd8);
    @(negedge clk);
    chk("t5_second_gnt1", {31'b0, bus.req1_ready}, 32'd1);
    q1.push_back(32'd6);
    drive();
    set0(1'b0, 32'd0, 32'd0, OP_ADD);
    set1(1'b0, 32'd0, 32'd0, OP_ADD);

`ifdef ALU_ARB_STATS_EN
    // 6. Saturating statistics counters (CNT_W = 4).
    drive();
    rst_n = 1'b0;
    @(negedge clk);
    q0.delete();
    q1.delete();
    drive();
    rst_n = 1'b1;
    set0(1'b1, 32'd1, 32'd1, OP_ADD);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      q0.push_back(32'd2);
    end
    drive();
    set1(1'b1, 32'd1, 32'd2, OP_SLL);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("t6_gnt_cnt0_sat", {28'b0, gnt_cnt0}, 32'd15);
        chk("t6_conflict_pre", {28'b0, conflict_cnt}, 32'd0);
      end
      chk("t6_rr_gnt1", {31'b0, bus.req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) q1.push_back(32'd4);
      else            q0.push_back(32'd2);
    end
    drive();
    set0(1'b0, 32'd0, 32'd0, OP_ADD);
    set1(1'b0, 32'd0, 32'd0, OP_ADD);
    @(negedge clk);
    chk("t6_conflict_cnt", {28'b0, conflict_cnt}, 32'd3);
    chk("t6_gnt_cnt1", {28'b0, gnt_cnt1}, 32'd2);
    chk("t6_gnt_cnt0_hold", {28'b0, gnt_cnt0}, 32'd15);
    drive();
    rst_n = 1'b0;
    @(negedge clk);
    q0.delete();
    q1.delete();
    drive();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_rst_gnt_cnt0", {28'b0, gnt_cnt0}, 32'd0);
    chk("t6_rst_gnt_cnt1", {28'b0, gnt_cnt1}, 32'd0);
    chk("t6_rst_conflict", {28'b0, conflict_cnt}, 32'd0);
`endif

    // Drain: every expected result must have been delivered.
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", q0.size() + q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
